// File: rtl/meduram_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// meduram_rd_arbiter_if
// Bundles every bus signal of one bank read arbiter: the per-agent request
// channel, the per-agent response channel, and the read slice of one RAM bank.
//
//   req_valid  [NB_RDAGENT]             agent -> arbiter  read request
//   req_addr   [ADDR_WIDTH*NB_RDAGENT]  agent -> arbiter  read address, slice i
//   req_ready  [NB_RDAGENT]             arbiter -> agent  one-hot grant
//   rsp_valid  [NB_RDAGENT]             arbiter -> agent  one-cycle response pulse
//   rsp_data   [DATA_WIDTH*NB_RDAGENT]  arbiter -> agent  response data, slice i
//   ram_rden                            arbiter -> bank   read enable
//   ram_rdaddr [ADDR_WIDTH]             arbiter -> bank   read address
//   ram_rddata [DATA_WIDTH]             bank -> arbiter   read data
//
// modport slave  : the arbiter's view.
// modport master : the surrounding environment (read agents plus the bank),
//                  which drives requests and the bank read data.
// -----------------------------------------------------------------------------
interface meduram_rd_arbiter_if #(
   parameter int NB_RDAGENT = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);

   logic [NB_RDAGENT-1:0]            req_valid;
   logic [ADDR_WIDTH*NB_RDAGENT-1:0] req_addr;
   logic [NB_RDAGENT-1:0]            req_ready;
   logic [NB_RDAGENT-1:0]            rsp_valid;
   logic [DATA_WIDTH*NB_RDAGENT-1:0] rsp_data;
   logic                             ram_rden;
   logic [ADDR_WIDTH-1:0]            ram_rdaddr;
   logic [DATA_WIDTH-1:0]            ram_rddata;

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output ram_rden,
      output ram_rdaddr,
      input  ram_rddata
   );

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  ram_rden,
      input  ram_rdaddr,
      output ram_rddata
   );

endinterface

// File: rtl/meduram_rd_arbiter.sv
// -----------------------------------------------------------------------------
// meduram_rd_arbiter
// Shares the read port of one RAM bank between NB_RDAGENT read agents.
// A round-robin arbiter grants at most one request per cycle, the granted
// address goes straight to the bank in the same cycle, and a small tracking
// pipeline, as deep as the bank read latency, remembers which agent issued each
// read so the returned word is delivered to that agent only.
// One instance per bank; sustains one read per cycle.
//
// Parameters
//   NB_RDAGENT  number of read agents (>= 2)
//   ADDR_WIDTH  bank address width
//   DATA_WIDTH  bank data width
//   RD_LATENCY  cycles from ram_rden to valid ram_rddata (1 or 2)
//   The interface instance must use the same NB_RDAGENT/ADDR_WIDTH/DATA_WIDTH.
//
// Ports
//   clk  single clock
//   rst  synchronous active-high reset
//   bus  meduram_rd_arbiter_if.slave: requests, grants, responses, bank port
//
// Timing: handshake in cycle T (req_valid[i] & req_ready[i]), rsp_valid[i]
// pulses in cycle T+RD_LATENCY+1. Responses cannot be back-pressured.
// -----------------------------------------------------------------------------
module meduram_rd_arbiter #(
   parameter int NB_RDAGENT = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input logic                 clk,
   input logic                 rst,
   meduram_rd_arbiter_if.slave bus
);

   localparam int PTR_W = (NB_RDAGENT > 1) ? $clog2(NB_RDAGENT) : 1;
   localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NB_RDAGENT - 1);
   localparam logic [PTR_W:0]   NB_EXT  = (PTR_W + 1)'(NB_RDAGENT);

   // Round-robin pointer: the agent searched first in the current cycle.
   logic [PTR_W-1:0] rr_ptr;

   // Arbitration results.
   logic             gnt_found;
   logic [PTR_W-1:0] gnt_id;
   logic [PTR_W:0]   cand;
   logic             hs;

   // Tracking pipeline: one entry per cycle of bank read latency.
   logic             trk_vld_p [RD_LATENCY];
   logic [PTR_W-1:0] trk_id_p  [RD_LATENCY];

   // Response registers.
   logic [NB_RDAGENT-1:0]            rsp_valid_q;
   logic [DATA_WIDTH*NB_RDAGENT-1:0] rsp_data_q;

   // ---------------------------------------------------------------------------
   // Stage: arbitration and issue (combinational, cycle T)
   // ---------------------------------------------------------------------------
   // Search rr_ptr, rr_ptr+1, ... modulo NB_RDAGENT. The candidate is kept one
   // bit wider than the pointer so the wrap works for non power-of-two counts.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int k = 0; k < NB_RDAGENT; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
         if (cand >= NB_EXT) begin
            cand = cand - NB_EXT;
         end
         if (!gnt_found && bus.req_valid[cand[PTR_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_id    = cand[PTR_W-1:0];
         end
      end
   end

   // A grant always completes a handshake: ready is only raised for an agent
   // whose valid is already high. Reset masks every grant so nothing issues.
   assign hs = gnt_found && !rst;

   always_comb begin
      bus.req_ready  = '0;
      bus.ram_rden   = 1'b0;
      bus.ram_rdaddr = '0;
      if (hs) begin
         bus.req_ready[gnt_id] = 1'b1;
         bus.ram_rden          = 1'b1;
         bus.ram_rdaddr        = bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // The agent after the one just served gets first priority next cycle; with
   // no handshake the pointer holds so priority is not lost while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (hs) begin
         rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + PTR_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Stage: tracking pipeline (_p0 .. _p[RD_LATENCY-1])
   // ---------------------------------------------------------------------------
   // Entry 0 holds the issue of cycle T during cycle T+1; the last entry lines
   // up with the cycle in which the bank presents ram_rddata for that issue.
   // Clearing it on reset is what drops reads that were in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            trk_vld_p[k] <= 1'b0;
            trk_id_p[k]  <= '0;
         end
      end else begin
         trk_vld_p[0] <= bus.ram_rden;
         trk_id_p[0]  <= gnt_id;
         for (int k = 1; k < RD_LATENCY; k++) begin
            trk_vld_p[k] <= trk_vld_p[k-1];
            trk_id_p[k]  <= trk_id_p[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage: response registers
   // ---------------------------------------------------------------------------
   // Only the slice of the agent that issued the read is updated; the other
   // slices keep their last word. rsp_valid is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= '0;
         if (trk_vld_p[RD_LATENCY-1]) begin
            rsp_valid_q[trk_id_p[RD_LATENCY-1]] <= 1'b1;
            rsp_data_q[trk_id_p[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] <= bus.ram_rddata;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/meduram_rd_arbiter.md
Name: meduram_rd_arbiter

Overview:
- Shares one bank read port (rden/rdaddr/rddata of a single RAM bank) between NB_RDAGENT read requesters.
- Uses round-robin arbitration and a valid/ready request handshake.
- Tracks in-flight reads through a latency-matched pipeline and routes each returned word to the requester that issued it.
- Sits between the read agents and one BramBank read slice; one instance per bank.

Parameters:
- NB_RDAGENT, 4, number of read requesters (>=2).
- ADDR_WIDTH, 8, RAM address width in bits.
- DATA_WIDTH, 32, RAM data width in bits.
- RD_LATENCY, 1, cycles from rden to valid rddata at the bank (1 or 2).

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NB_RDAGENT  per-agent read request.
- req_addr  input  ADDR_WIDTH*NB_RDAGENT  per-agent read address; slice i = [ADDR_WIDTH*i +: ADDR_WIDTH].
- req_ready  output  NB_RDAGENT  per-agent grant; a handshake completes on req_valid[i] & req_ready[i].
- rsp_valid  output  NB_RDAGENT  one-cycle pulse per completed read.
- rsp_data  output  DATA_WIDTH*NB_RDAGENT  per-agent read data; slice i valid while rsp_valid[i]=1.
- ram_rden  output  1  bank read enable.
- ram_rdaddr  output  ADDR_WIDTH  bank read address.
- ram_rddata  input  DATA_WIDTH  bank read data, valid RD_LATENCY cycles after ram_rden.

Behaviour:
- Clock/reset: one clock. Reset is synchronous and active-high on rst; it is sampled only on the rising edge of clk.
- Reset values:
  - rr_ptr=0.
  - Issue pipeline (valid + agent id, depth RD_LATENCY) cleared.
  - rsp_valid=0, rsp_data=0.
  - While rst=1: req_ready=0 and ram_rden=0.
- Arbitration (combinational, every cycle):
  - grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, …, wrapping modulo NB_RDAGENT.
  - req_ready is one-hot equal to grant, or all zero if no request.
  - req_ready never asserts for an agent whose req_valid=0.
- Issue:
  - ram_rden = |req_valid (and !rst).
  - ram_rdaddr = req_addr slice of the granted agent, driven combinationally in the same cycle; ram_rdaddr=0 when idle.
- Pointer:
  - On a handshake with agent g, rr_ptr <= (g+1) mod NB_RDAGENT.
  - With no request, rr_ptr holds.
  - Fairness: a continuously requesting agent waits at most NB_RDAGENT-1 grants.
- Throughput: one read per cycle sustained; no bubbles between back-to-back requests.
- Tracking:
  - Stage 0 of the pipeline captures {ram_rden, g}; it shifts every cycle.
  - Stage RD_LATENCY-1 aligns with the cycle in which ram_rddata is valid.
- Response:
  - On the edge after that cycle: rsp_valid[id] <= 1 and the rsp_data slice id <= ram_rddata.
  - Other slices of rsp_data hold their last value.
  - rsp_valid is all zero otherwise.
  - Total latency from handshake to rsp_valid = RD_LATENCY+1 cycles.
- No response backpressure: agents must accept rsp_valid pulses unconditionally.
- Agent changes:
  - An agent may drop req_valid or change req_addr only after a handshake; behaviour otherwise is undefined but must never produce a response for a non-handshaked request.
  - An agent may request in consecutive cycles; it is then granted only in turn.
- Simultaneous: response for an earlier read and a new grant to the same agent in the same cycle are independent; both occur.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid is produced for them; the first grant after reset goes to the lowest-index requesting agent.
- Wrap: rr_ptr wraps from NB_RDAGENT-1 to 0.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid=4'b0100, addr2=0x10, RAM[0x10]=0xDEADBEEF, RD_LATENCY=1.
  - Required: req_ready=4'b0100 in the same cycle; ram_rdaddr=0x10; rsp_valid=4'b0100 with rsp_data slice 2 = 0xDEADBEEF exactly 2 cycles later, for one cycle.
- Round-robin:
  - Stimulus: all 4 agents hold req_valid=1 for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3, one per cycle; 8 rsp_valid pulses in the same order.
- Pointer wrap and skip:
  - Stimulus: grant agent 3, then req_valid=4'b1010.
  - Required: next grant is agent 1, then agent 3.
- Latency 2 pipelining:
  - Stimulus: RD_LATENCY=2; agents 0 and 1 alternate back-to-back at addrs 0x01/0x02 holding 0xA/0xB.
  - Required: each response arrives 3 cycles after its grant, with correct agent/data pairing and no bubbles.
- Reset mid-operation:
  - Stimulus: assert rst one cycle after the grant to agent 1.
  - Required: no rsp_valid for that read; after release, with req_valid=4'b0110, agent 1 is granted first.
- Idle:
  - Stimulus: req_valid=0 for 10 cycles.
  - Required: ram_rden=0, req_ready=0, rsp_valid=0, rr_ptr unchanged.
